// File: rtl/fwd_pkg.sv
// Shared select encodings and controller state for the forwarding/hazard block.
package fwd_pkg;

  // Forward-select codes presented to the EX operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in MEM
  localparam logic [1:0] FWD_LD  = 2'b11;  // load data arriving in MEM

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_src_cmp.sv
// One source operand: compares its address against the EX and MEM
// destinations, picks the select for next cycle and flags a load-use hazard.
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int LOAD_BYPASS = 0
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_valid,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic              ex_wr,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic              mem_wr,
  output logic [1:0]        next_sel,
  output logic              lu_hit
);

  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = src_valid & ex_wr  & (src_addr == ex_dst_addr);
  assign hit_mem = src_valid & mem_wr & (src_addr == mem_dst_addr);

  // EX is the younger producer so it beats MEM. A non-bypassed load hit
  // yields RF here; the bubble it raises zeroes the register anyway.
  always_comb begin
    next_sel = FWD_RF;
    lu_hit   = 1'b0;
    if (hit_ex) begin
      if (ex_load) begin
        if (LOAD_BYPASS != 0) next_sel = FWD_LD;
        else                  lu_hit   = 1'b1;
      end else begin
        next_sel = FWD_MEM;
      end
    end else if (hit_mem) begin
      next_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding + hazard controller: per-source selects computed in ID and
// registered for EX, load-use bubble, and whole-pipe freeze on mem_busy.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_BYPASS = 0,
  parameter int CNT_W       = 16,
  parameter int WAIT_MAX    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [REG_AW-1:0]         ex_dst_addr,
  input  logic                      ex_wr,
  input  logic                      ex_load,
  input  logic [REG_AW-1:0]         mem_dst_addr,
  input  logic                      mem_wr,
  input  logic                      mem_busy,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      stall_all,
  output logic [CNT_W-1:0]          lu_stall_cnt,
  output logic [CNT_W-1:0]          mem_stall_cnt,
  output logic                      mem_timeout
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  // Entry cycle is uncounted, so the last counted busy cycle is WAIT_MAX-1
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  logic [NUM_SRC-1:0][1:0] sel_d;
  logic [NUM_SRC-1:0][1:0] sel_q;
  logic [NUM_SRC-1:0]      lu_vec;
  logic                    lu_hit;
  fwd_state_e              state, state_n;
  logic [WAIT_W-1:0]       wait_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_cmp #(
      .REG_AW      (REG_AW),
      .LOAD_BYPASS (LOAD_BYPASS)
    ) u_cmp (
      .src_addr     (id_src_addr[i*REG_AW +: REG_AW]),
      .src_valid    (id_src_valid[i]),
      .ex_dst_addr  (ex_dst_addr),
      .ex_wr        (ex_wr),
      .ex_load      (ex_load),
      .mem_dst_addr (mem_dst_addr),
      .mem_wr       (mem_wr),
      .next_sel     (sel_d[i]),
      .lu_hit       (lu_vec[i])
    );
  end

  assign lu_hit  = |lu_vec;
  assign fwd_sel = sel_q;

  // Next state and hazard outputs; a freeze masks the bubble, flush kills it
  always_comb begin
    state_n      = state;
    stall_all    = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          stall_all = 1'b1;
          state_n   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) stall_all = 1'b1;
        else          state_n   = RUN;
      end
      default: state_n = RUN;
    endcase
    if (!stall_all && !flush && lu_hit) begin
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end
    if (flush) state_n = RUN;
  end

  // State register and the registered forward selects for EX
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sel_q <= '0;
    end else begin
      state <= state_n;
      if (flush)             sel_q <= '0;
      else if (stall_all)    sel_q <= sel_q;
      else if (bubble_id_ex) sel_q <= '0;
      else                   sel_q <= sel_d;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (bubble_id_ex && (lu_stall_cnt != '1))
        lu_stall_cnt <= lu_stall_cnt + 1'b1;
      if (stall_all && (mem_stall_cnt != '1))
        mem_stall_cnt <= mem_stall_cnt + 1'b1;
    end
  end

  // Wait watchdog: restarts on entering MEM_WAIT, timeout is sticky until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (mem_busy && !flush) begin
      if (state == RUN) begin
        wait_cnt <= '0;
      end else begin
        if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
        else                       wait_cnt    <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two instances (no load bypass / WAIT_MAX=3, and
// load bypass / WAIT_MAX=255) share one stimulus stream. A rule-level model
// is compared on every negedge; directed literals pin key points.
module tb_fwd_hazard_ctrl;

  localparam int AW = 3;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          rst, flush, ex_wr, ex_load, mem_wr, mem_busy;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0] id_src_valid;
  logic [AW-1:0] ex_dst_addr, mem_dst_addr;

  logic [3:0]    fwd_o  [2];
  logic          stl_o  [2];
  logic          bub_o  [2];
  logic          sa_o   [2];
  logic [15:0]   lu_o   [2];
  logic [15:0]   ms_o   [2];
  logic          tmo_o  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_BYPASS(0), .CNT_W(16), .WAIT_MAX(3)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
    .ex_dst_addr(ex_dst_addr), .ex_wr(ex_wr), .ex_load(ex_load), .mem_dst_addr(mem_dst_addr),
    .mem_wr(mem_wr), .mem_busy(mem_busy), .fwd_sel(fwd_o[0]), .stall_if_id(stl_o[0]),
    .bubble_id_ex(bub_o[0]), .stall_all(sa_o[0]), .lu_stall_cnt(lu_o[0]),
    .mem_stall_cnt(ms_o[0]), .mem_timeout(tmo_o[0]));

  fwd_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_BYPASS(1), .CNT_W(16), .WAIT_MAX(255)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
    .ex_dst_addr(ex_dst_addr), .ex_wr(ex_wr), .ex_load(ex_load), .mem_dst_addr(mem_dst_addr),
    .mem_wr(mem_wr), .mem_busy(mem_busy), .fwd_sel(fwd_o[1]), .stall_if_id(stl_o[1]),
    .bubble_id_ex(bub_o[1]), .stall_all(sa_o[1]), .lu_stall_cnt(lu_o[1]),
    .mem_stall_cnt(ms_o[1]), .mem_timeout(tmo_o[1]));

  // ---------------- behavioural model ----------------
  bit        m_byp [2] = '{1'b0, 1'b1};
  int        m_wmax[2] = '{3, 255};
  logic [3:0] m_fwd [2];
  int        m_lu  [2];
  int        m_ms  [2];
  int        m_run [2];
  bit        m_tmo [2];

  // Selects and load-use flag straight from the forwarding rules
  function automatic void model_comb(input bit byp, output logic [3:0] sel, output bit lu);
    logic [AW-1:0] a;
    bit he, hm;
    sel = '0;
    lu  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      a  = id_src_addr[i*AW +: AW];
      he = id_src_valid[i] && ex_wr  && (a == ex_dst_addr);
      hm = id_src_valid[i] && mem_wr && (a == mem_dst_addr);
      if (he && ex_load && !byp) lu = 1'b1;
      if (he)      sel[i*2 +: 2] = (ex_load ? 2'b11 : 2'b10);
      else if (hm) sel[i*2 +: 2] = 2'b01;
    end
  endfunction

  always @(posedge clk) begin
    logic [3:0] s;
    bit lu, bub;
    for (int d = 0; d < 2; d++) begin
      model_comb(m_byp[d], s, lu);
      bub = lu && !flush && !mem_busy;
      if (rst) begin
        m_fwd[d] = '0; m_lu[d] = 0; m_ms[d] = 0; m_run[d] = 0; m_tmo[d] = 1'b0;
      end else begin
        if (flush)         m_fwd[d] = '0;
        else if (mem_busy) m_fwd[d] = m_fwd[d];
        else if (bub)      m_fwd[d] = '0;
        else               m_fwd[d] = s;
        if (bub && m_lu[d] < 65535) m_lu[d]++;
        if (mem_busy && m_ms[d] < 65535) m_ms[d]++;
        m_run[d] = mem_busy ? m_run[d] + 1 : 0;
        // first busy cycle enters MEM_WAIT, WAIT_MAX more cycles there trip it
        if (m_run[d] >= m_wmax[d] + 1) m_tmo[d] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0] s;
    bit lu, bub;
    for (int d = 0; d < 2; d++) begin
      model_comb(m_byp[d], s, lu);
      bub = lu && !flush && !mem_busy;
      chk($sformatf("m%0d_fwd_sel", d),   {28'd0, fwd_o[d]}, {28'd0, m_fwd[d]});
      chk($sformatf("m%0d_stall_all", d), {31'd0, sa_o[d]},  {31'd0, mem_busy});
      chk($sformatf("m%0d_bubble", d),    {31'd0, bub_o[d]}, {31'd0, bub});
      chk($sformatf("m%0d_stall_if_id", d), {31'd0, stl_o[d]}, {31'd0, bub});
      chk($sformatf("m%0d_lu_cnt", d),    {16'd0, lu_o[d]},  m_lu[d]);
      chk($sformatf("m%0d_mem_cnt", d),   {16'd0, ms_o[d]},  m_ms[d]);
      chk($sformatf("m%0d_timeout", d),   {31'd0, tmo_o[d]}, {31'd0, m_tmo[d]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; ex_wr = 0; ex_load = 0; mem_wr = 0; mem_busy = 0;
    id_src_addr = '0; id_src_valid = '0; ex_dst_addr = '0; mem_dst_addr = '0;
  endtask

  task automatic alu_r1_src0();
    idle();
    ex_dst_addr = 3'd1; ex_wr = 1; id_src_addr = {3'd0, 3'd1}; id_src_valid = 2'b01;
  endtask

  task automatic load_r2_src1();
    idle();
    ex_dst_addr = 3'd2; ex_wr = 1; ex_load = 1; id_src_addr = {3'd2, 3'd0}; id_src_valid = 2'b10;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("reset_fwd0", {28'd0, fwd_o[0]}, 32'h0);
    chk("reset_lu0",  {16'd0, lu_o[0]},  32'h0);
    chk("reset_ms0",  {16'd0, ms_o[0]},  32'h0);
    chk("reset_tmo0", {31'd0, tmo_o[0]}, 32'h0);

    // ALU producer in EX forwards from MEM next cycle
    alu_r1_src0();
    #1 chk("t1_no_stall", {31'd0, stl_o[0]}, 32'h0);
    step(); idle();
    #1 chk("t1_sel", {28'd0, fwd_o[0]}, 32'h2);
    step();

    // Load-use: bubble without bypass, direct load data with bypass
    load_r2_src1();
    #1;
    chk("t2_stall",  {31'd0, stl_o[0]}, 32'h1);
    chk("t2_bubble", {31'd0, bub_o[0]}, 32'h1);
    chk("t2_sel0",   {28'd0, fwd_o[0]}, 32'h0);
    chk("t3_nobub",  {31'd0, bub_o[1]}, 32'h0);
    step();
    ex_wr = 0; ex_load = 0; mem_dst_addr = 3'd2; mem_wr = 1;
    #1;
    chk("t2_sel_bub", {28'd0, fwd_o[0]}, 32'h0);
    chk("t2_lu_cnt",  {16'd0, lu_o[0]},  32'h1);
    chk("t3_sel_ld",  {28'd0, fwd_o[1]}, 32'hC);
    step(); idle();
    #1 chk("t2_sel_wb", {28'd0, fwd_o[0]}, 32'h4);

    // Youngest producer wins; unread source never forwards
    ex_dst_addr = 3'd3; ex_wr = 1; mem_dst_addr = 3'd3; mem_wr = 1;
    id_src_addr = {3'd3, 3'd3}; id_src_valid = 2'b01;
    step();
    #1 chk("t4_ex_wins", {28'd0, fwd_o[0]}, 32'h2);
    ex_dst_addr = 3'd5;
    step();
    #1 chk("t4_mem_only", {28'd0, fwd_o[0]}, 32'h1);
    id_src_valid = 2'b00;
    step();
    #1 chk("t4_invalid", {28'd0, fwd_o[0]}, 32'h0);

    // Short busy burst stays under the watchdog
    idle(); mem_busy = 1;
    repeat (3) step();
    mem_busy = 0;
    #1;
    chk("t6_short_tmo", {31'd0, tmo_o[0]}, 32'h0);
    chk("t6_short_ms",  {16'd0, ms_o[0]},  32'h3);

    // Freeze during a load-use hazard, then a single bubble on release
    alu_r1_src0();
    step();
    load_r2_src1(); mem_busy = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t5_sa_%0d", k),   {31'd0, sa_o[0]},  32'h1);
      chk($sformatf("t5_bub_%0d", k),  {31'd0, bub_o[0]}, 32'h0);
      chk($sformatf("t5_hold_%0d", k), {28'd0, fwd_o[0]}, 32'h2);
      step();
    end
    mem_busy = 0;
    #1;
    chk("t5_rel_bub", {31'd0, bub_o[0]}, 32'h1);
    chk("t5_rel_sa",  {31'd0, sa_o[0]},  32'h0);
    chk("t5_ms",      {16'd0, ms_o[0]},  32'h7);
    chk("t5_tmo0",    {31'd0, tmo_o[0]}, 32'h1);
    chk("t5_tmo1",    {31'd0, tmo_o[1]}, 32'h0);
    step(); idle();
    #1;
    chk("t5_lu", {16'd0, lu_o[0]},  32'h2);
    chk("t5_sel", {28'd0, fwd_o[0]}, 32'h0);

    // Long busy: timeout stays set; flush beats a coincident load-use
    mem_busy = 1;
    repeat (5) step();
    mem_busy = 0;
    #1;
    chk("t6_tmo_sticky", {31'd0, tmo_o[0]}, 32'h1);
    chk("t6_ms",         {16'd0, ms_o[0]},  32'd12);
    alu_r1_src0();
    step();
    #1 chk("t6_pre_sel", {28'd0, fwd_o[0]}, 32'h2);
    load_r2_src1(); flush = 1;
    #1;
    chk("t6_flush_bub",   {31'd0, bub_o[0]}, 32'h0);
    chk("t6_flush_stall", {31'd0, stl_o[0]}, 32'h0);
    step(); idle();
    #1;
    chk("t6_flush_sel0", {28'd0, fwd_o[0]}, 32'h0);
    chk("t6_flush_sel1", {28'd0, fwd_o[1]}, 32'h0);
    chk("t6_lu_same",    {16'd0, lu_o[0]},  32'h2);
    chk("t6_tmo_held",   {31'd0, tmo_o[0]}, 32'h1);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
